// File: rtl/mesi_isc_fifo_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mesi_isc_fifo_rd_arb_pkg
// Description : Shared definitions for the FIFO read arbiter and its
//               round-robin picker. Holds the default CPU count, the matching
//               index width and the output-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mesi_isc_fifo_rd_arb_pkg;

    localparam int CPU_COUNT_DEF      = 4;
    localparam int CPU_COUNT_LOG2_DEF = 2;

    // Output register stage: EMPTY holds nothing, FULL holds one word.
    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage : mesi_isc_fifo_rd_arb_pkg
`default_nettype wire

// File: rtl/mesi_isc_fifo_rd_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mesi_isc_rr_pick
// Description : Combinational round-robin picker. Grants the first set bit
//               of req searching upward from ptr, wrapping modulo CPU_COUNT.
//               Kept standalone so other request paths can share it.
// Ports       : req        - request vector, bit n = source n
//               ptr        - highest-priority source index this cycle
//               gnt_onehot - one-hot grant (zero when no request)
//               gnt_idx    - binary index of the granted source
//               gnt_valid  - at least one request was present
// Revision    : 1.0 - initial release
// ============================================================================
module mesi_isc_rr_pick
    import mesi_isc_fifo_rd_arb_pkg::*;
#(
    parameter int CPU_COUNT      = CPU_COUNT_DEF,
    parameter int CPU_COUNT_LOG2 = CPU_COUNT_LOG2_DEF
) (
    input  logic [CPU_COUNT-1:0]      req,
    input  logic [CPU_COUNT_LOG2-1:0] ptr,
    output logic [CPU_COUNT-1:0]      gnt_onehot,
    output logic [CPU_COUNT_LOG2-1:0] gnt_idx,
    output logic                      gnt_valid
);

    // One extra bit so ptr+offset cannot overflow before the modulo fold.
    localparam logic [CPU_COUNT_LOG2:0] c_count = (CPU_COUNT_LOG2+1)'(CPU_COUNT);

    always_comb begin
        logic [CPU_COUNT_LOG2:0]   w_sum;
        logic [CPU_COUNT_LOG2-1:0] w_idx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        gnt_valid  = 1'b0;
        w_sum      = '0;
        w_idx      = '0;
        for (int i = 0; i < CPU_COUNT; i++) begin
            // ptr < CPU_COUNT and i < CPU_COUNT, so one subtraction wraps.
            w_sum = {1'b0, ptr} + (CPU_COUNT_LOG2+1)'(i);
            if (w_sum >= c_count) begin
                w_sum = w_sum - c_count;
            end
            w_idx = w_sum[CPU_COUNT_LOG2-1:0];
            if (!gnt_valid && req[w_idx]) begin
                gnt_valid         = 1'b1;
                gnt_idx           = w_idx;
                gnt_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule : mesi_isc_rr_pick
`default_nettype wire

// File: rtl/mesi_isc_fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : mesi_isc_fifo_rd_arb
// Description : Read-side consumer for a bank of per-CPU FIFOs. Picks one
//               non-empty FIFO per cycle by round-robin, pops it with a
//               one-cycle rd pulse and registers the popped word into a
//               single-entry valid/ready output stage.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               fifo_empty_i  - empty flag per FIFO
//               fifo_data_i   - head word per FIFO, flattened (n*DATA_WIDTH)
//               fifo_rd_o     - one-hot (or zero) pop pulse per FIFO
//               out_valid_o   - out_data_o/out_src_o hold a word
//               out_data_o    - popped word
//               out_src_o     - index of the FIFO the word came from
//               out_ready_i   - downstream accepts when valid & ready
// Options     : MESI_ISC_FIFO_RD_ARB_DBG_EN adds dbg_rd_empty_o (sticky
//               pop-of-empty flag) and dbg_pop_cnt_o (16-bit saturating pop
//               counter per source).
// Revision    : 1.0 - initial release
// ============================================================================
module mesi_isc_fifo_rd_arb
    import mesi_isc_fifo_rd_arb_pkg::*;
#(
    parameter int CPU_COUNT      = CPU_COUNT_DEF,
    parameter int CPU_COUNT_LOG2 = CPU_COUNT_LOG2_DEF,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CPU_COUNT-1:0]            fifo_empty_i,
    input  logic [CPU_COUNT*DATA_WIDTH-1:0] fifo_data_i,
    output logic [CPU_COUNT-1:0]            fifo_rd_o,
    output logic                            out_valid_o,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic [CPU_COUNT_LOG2-1:0]       out_src_o,
    input  logic                            out_ready_i
`ifdef MESI_ISC_FIFO_RD_ARB_DBG_EN
    ,
    output logic                            dbg_rd_empty_o,
    output logic [CPU_COUNT*16-1:0]         dbg_pop_cnt_o
`endif
);

    localparam logic [CPU_COUNT_LOG2-1:0] c_last_idx = CPU_COUNT_LOG2'(CPU_COUNT-1);

    out_state_e                r_state;
    out_state_e                w_state_nxt;
    logic [CPU_COUNT_LOG2-1:0] r_rr_ptr;
    logic [CPU_COUNT_LOG2-1:0] r_src;
    logic [DATA_WIDTH-1:0]     r_data;

    logic [DATA_WIDTH-1:0]     w_fifo_data [CPU_COUNT];
    logic [CPU_COUNT-1:0]      w_req;
    logic [CPU_COUNT-1:0]      w_gnt_onehot;
    logic [CPU_COUNT_LOG2-1:0] w_gnt_idx;
    logic                      w_gnt_valid;
    logic                      w_can_load;
    logic                      w_grant;

    for (genvar n = 0; n < CPU_COUNT; n++) begin : g_unpack
        assign w_fifo_data[n] = fifo_data_i[n*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_req = ~fifo_empty_i;

    // The output register can take a new word when empty, or when the word
    // it holds is leaving this cycle.
    assign w_can_load = (r_state == OUT_EMPTY) | out_ready_i;

    mesi_isc_rr_pick #(
        .CPU_COUNT      (CPU_COUNT),
        .CPU_COUNT_LOG2 (CPU_COUNT_LOG2)
    ) u_rr_pick (
        .req        (w_req),
        .ptr        (r_rr_ptr),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .gnt_valid  (w_gnt_valid)
    );

    assign w_grant   = w_can_load & w_gnt_valid;
    assign fifo_rd_o = w_grant ? w_gnt_onehot : '0;

    // Output-stage state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OUT_EMPTY: begin
                if (w_grant) begin
                    w_state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (w_grant) begin
                    w_state_nxt = OUT_FULL;
                end else if (out_ready_i) begin
                    w_state_nxt = OUT_EMPTY;
                end
            end
            default: w_state_nxt = OUT_EMPTY;
        endcase
    end

    // Data path and round-robin pointer; both only move on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= '0;
            r_src    <= '0;
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_data   <= w_fifo_data[w_gnt_idx];
            r_src    <= w_gnt_idx;
            r_rr_ptr <= (w_gnt_idx == c_last_idx) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    assign out_valid_o = (r_state == OUT_FULL);
    assign out_data_o  = r_data;
    assign out_src_o   = r_src;

`ifdef MESI_ISC_FIFO_RD_ARB_DBG_EN
    logic r_rd_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_empty <= 1'b0;
        end else if (|(fifo_rd_o & fifo_empty_i)) begin
            r_rd_empty <= 1'b1;
        end
    end

    assign dbg_rd_empty_o = r_rd_empty;

    for (genvar n = 0; n < CPU_COUNT; n++) begin : g_pop_cnt
        logic [15:0] r_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (fifo_rd_o[n] && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign dbg_pop_cnt_o[n*16 +: 16] = r_cnt;
    end
`endif

endmodule : mesi_isc_fifo_rd_arb
`default_nettype wire

// File: tb/tb_mesi_isc_fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesi_isc_fifo_rd_arb
// Description : Self-checking bench for mesi_isc_fifo_rd_arb. Emulates the
//               source FIFOs with small circular buffers and predicts the
//               output stream with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesi_isc_fifo_rd_arb;

    localparam int N  = 4;
    localparam int L  = 2;
    localparam int W  = 32;
    localparam int QD = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   fifo_empty_i;
    logic [N*W-1:0] fifo_data_i;
    logic [N-1:0]   fifo_rd_o;
    logic           out_valid_o;
    logic [W-1:0]   out_data_o;
    logic [L-1:0]   out_src_o;
    logic           out_ready_i;
`ifdef MESI_ISC_FIFO_RD_ARB_DBG_EN
    logic           dbg_rd_empty_o;
    logic [N*16-1:0] dbg_pop_cnt_o;
`endif

    mesi_isc_fifo_rd_arb #(
        .CPU_COUNT      (N),
        .CPU_COUNT_LOG2 (L),
        .DATA_WIDTH     (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_rd_o    (fifo_rd_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_src_o    (out_src_o),
        .out_ready_i  (out_ready_i)
`ifdef MESI_ISC_FIFO_RD_ARB_DBG_EN
        ,
        .dbg_rd_empty_o (dbg_rd_empty_o),
        .dbg_pop_cnt_o  (dbg_pop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Source FIFO emulation
    logic [W-1:0] mem  [N][QD];
    int           head [N];
    int           cnt  [N];

    // Reference model of the output stage
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_ptr;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [N-1:0] last_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic refresh();
        for (int n = 0; n < N; n++) begin
            fifo_empty_i[n] = (cnt[n] == 0);
            fifo_data_i[n*W +: W] = (cnt[n] != 0) ? mem[n][head[n]] : (32'hDEAD_0000 | n);
        end
    endtask

    task automatic push(input int n, input logic [W-1:0] d);
        if (cnt[n] < QD) begin
            mem[n][(head[n] + cnt[n]) % QD] = d;
            cnt[n]++;
        end
    endtask

    task automatic clear_model();
        for (int n = 0; n < N; n++) begin
            head[n] = 0;
            cnt[n]  = 0;
        end
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = 0;
    endtask

    // Which source should be popped this cycle, from the FIFO occupancy,
    // the output-stage occupancy and the rotating priority.
    task automatic exp_grant(input bit rdy, output bit gv, output int gi);
        gv = 1'b0;
        gi = 0;
        if (!m_valid || rdy) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (!gv && cnt[k] > 0) begin
                    gv = 1'b1;
                    gi = k;
                end
            end
        end
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input bit rdy);
        bit gv;
        int gi;
        out_ready_i = rdy;
        refresh();
        #2;
        exp_grant(rdy, gv, gi);
        last_rd = fifo_rd_o;
        chk("rd_onehot", fifo_rd_o, gv ? (64'd1 << gi) : 64'd0);
        chk("rd_to_empty", fifo_rd_o & fifo_empty_i, 0);
        chk("valid", out_valid_o, m_valid);
        if (m_valid) begin
            chk("data", out_data_o, m_data);
            chk("src", out_src_o, m_src);
        end
        @(posedge clk);
        if (gv) begin
            m_data    = mem[gi][head[gi]];
            m_src     = gi;
            m_valid   = 1'b1;
            head[gi]  = (head[gi] + 1) % QD;
            cnt[gi]--;
            m_ptr     = (gi + 1) % N;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_model();
        refresh();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        out_ready_i = 1'b1;
        clear_model();
        refresh();
        do_reset();

        // Reset state, then idle with all FIFOs empty.
        chk("rst_valid", out_valid_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_src", out_src_o, 0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            chk("idle_rd", last_rd, 0);
        end

        // All four FIFOs hold two words: strict rotation, one word per cycle.
        for (int n = 0; n < N; n++) begin
            push(n, 32'h1000_0000 + n * 16 + 0);
            push(n, 32'h1000_0000 + n * 16 + 1);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            chk("rr_order", last_rd, 64'd1 << (i % N));
            chk("rr_word", out_data_o, 32'h1000_0000 + (i % N) * 16 + (i / N));
        end
`ifdef MESI_ISC_FIFO_RD_ARB_DBG_EN
        for (int n = 0; n < N; n++) begin
            chk("dbg_pop_cnt", dbg_pop_cnt_o[n*16 +: 16], 2);
        end
        chk("dbg_rd_empty", dbg_rd_empty_o, 0);
`endif
        step(1'b1);
        step(1'b1);

        // FIFO 2 alone holds two words: back-to-back pops of the same FIFO.
        push(2, 32'hA1A1_A1A1);
        push(2, 32'hA2A2_A2A2);
        step(1'b1);
        chk("f2_rd1", last_rd, 4'b0100);
        chk("f2_data1", out_data_o, 32'hA1A1_A1A1);
        chk("f2_src1", out_src_o, 2);
        step(1'b1);
        chk("f2_rd2", last_rd, 4'b0100);
        chk("f2_data2", out_data_o, 32'hA2A2_A2A2);
        step(1'b1);
        chk("f2_rd3", last_rd, 0);
        chk("f2_drained", out_valid_o, 0);

        // Backpressure: output held for 5 cycles, nothing popped.
        push(0, 32'hB000_0001);
        push(0, 32'hB000_0002);
        push(0, 32'hB000_0003);
        step(1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            chk("bp_rd", last_rd, 0);
            chk("bp_hold", out_data_o, 32'hB000_0001);
            chk("bp_valid", out_valid_o, 1);
        end
        step(1'b1);
        chk("bp_release_rd", last_rd, 4'b0001);
        chk("bp_next", out_data_o, 32'hB000_0002);
        step(1'b1);
        step(1'b1);
        step(1'b1);

        // Write into empty FIFO 1: popped next cycle, visible the cycle after.
        push(1, 32'hC0FF_EE01);
        step(1'b1);
        chk("lat_rd", last_rd, 4'b0010);
        chk("lat_valid", out_valid_o, 1);
        chk("lat_data", out_data_o, 32'hC0FF_EE01);
        step(1'b1);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            for (int n = 0; n < N; n++) begin
                if ($urandom_range(99) < 30) begin
                    push(n, $urandom);
                end
            end
            step($urandom_range(99) < 70);
        end

        // Asynchronous reset with a word held in the output stage.
        push(3, 32'h5555_AAAA);
        for (int i = 0; i < 4 && !m_valid; i++) begin
            step(1'b0);
        end
        chk("pre_arst_valid", out_valid_o, m_valid);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_data", out_data_o, 0);
        clear_model();
        refresh();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
        end
`ifdef MESI_ISC_FIFO_RD_ARB_DBG_EN
        chk("dbg_rd_empty_end", dbg_rd_empty_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mesi_isc_fifo_rd_arb
`default_nettype wire
